// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator: turns one command into an AW/W/B
// write or an AR/R read and hands back one response.
module axil_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;

    logic aw_hs, w_hs;

    assign aw_hs = awvalid_q & m_axil_awready;
    assign w_hs  = wvalid_q & m_axil_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Every handshake output is computed one cycle ahead so all outputs are flops.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    write_d     = cmd_write;
                    addr_d      = cmd_addr;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axil_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_axil_bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && m_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axil_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = m_axil_rresp;
                    rsp_rdata_d = m_axil_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_write      = write_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = PROT;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = PROT;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master: a delay-configurable AXI4-Lite responder,
// a vector table, hand-written corner sequences and a randomized scoreboard run.
module tb_axil_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [31:0] m_axil_wdata, m_axil_rdata;
    logic [3:0]  m_axil_wstrb;
    logic [1:0]  m_axil_bresp, m_axil_rresp;
    logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic        m_axil_rvalid, m_axil_rready;

    always #5 clk = ~clk;

    axil_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

    // Responder knobs, written by the stimulus process only while idle
    int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
    logic [1:0]  cfg_resp = 2'b00;
    bit          cfg_rover = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;

    logic [31:0] slave_mem [logic [15:0]];
    logic [31:0] model_mem [logic [15:0]];
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

    // Responder: drives its inputs at negedge; values seen at the previous negedge
    // are exactly those present at the rising edge in between.
    initial begin : responder
        bit          aw_got, w_got, b_pend, ar_got;
        int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic [15:0] wr_addr, rd_addr;
        logic [31:0] wr_data;
        logic [3:0]  wr_strb;
        logic        p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
        logic [15:0] p_awaddr, p_araddr;
        logic [31:0] p_wdata;
        logic [3:0]  p_wstrb;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0;
        m_axil_bresp = 2'b00; m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
        m_axil_rdata = 32'h0; m_axil_rresp = 2'b00;
        aw_got = 0; w_got = 0; b_pend = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_strb = '0;
        {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0;
                m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
                aw_got = 0; w_got = 0; b_pend = 0; ar_got = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
                continue;
            end
            // Valids with their payload must hold until accepted, then drop
            if (p_awv && !p_awr)
                check("aw_hold", 64'({m_axil_awvalid, m_axil_awaddr}), 64'({1'b1, p_awaddr}));
            if (p_awv && p_awr) check("aw_drop", 64'(m_axil_awvalid), 64'(0));
            if (p_wv && !p_wr)
                check("w_hold", 64'({m_axil_wvalid, m_axil_wdata, m_axil_wstrb}),
                      64'({1'b1, p_wdata, p_wstrb}));
            if (p_wv && p_wr) check("w_drop", 64'(m_axil_wvalid), 64'(0));
            if (p_arv && !p_arr)
                check("ar_hold", 64'({m_axil_arvalid, m_axil_araddr}), 64'({1'b1, p_araddr}));
            if (m_axil_awvalid || m_axil_arvalid)
                check("prot", 64'({m_axil_awprot, m_axil_arprot}), 64'(0));
            if (m_axil_rready)
                check("rready_only_rd_data", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready,
                      m_axil_arvalid, rsp_valid}), 64'(0));

            if (p_awv && p_awr) begin n_aw++; aw_got = 1; wr_addr = p_awaddr; end
            if (p_wv && p_wr)   begin n_w++;  w_got = 1;  wr_data = p_wdata; wr_strb = p_wstrb; end
            if (aw_got && w_got && !b_pend) begin
                slave_mem[wr_addr] = merge(slave_mem.exists(wr_addr) ? slave_mem[wr_addr] : 32'h0,
                                           wr_data, wr_strb);
                b_pend = 1; b_cnt = 0;
            end
            if (p_bv && p_br)   begin n_b++; aw_got = 0; w_got = 0; b_pend = 0; end
            if (p_arv && p_arr) begin n_ar++; ar_got = 1; rd_addr = p_araddr; r_cnt = 0; end
            if (p_rv && p_rr)   begin n_r++; ar_got = 0; end

            m_axil_awready = 1'b0;
            if (m_axil_awvalid && !aw_got) begin
                if (aw_cnt >= cfg_aw_dly) m_axil_awready = 1'b1; else aw_cnt++;
            end else aw_cnt = 0;
            m_axil_wready = 1'b0;
            if (m_axil_wvalid && !w_got) begin
                if (w_cnt >= cfg_w_dly) m_axil_wready = 1'b1; else w_cnt++;
            end else w_cnt = 0;
            m_axil_arready = 1'b0;
            if (m_axil_arvalid && !ar_got) begin
                if (ar_cnt >= cfg_ar_dly) m_axil_arready = 1'b1; else ar_cnt++;
            end else ar_cnt = 0;
            m_axil_bvalid = 1'b0;
            if (b_pend) begin
                if (b_cnt >= cfg_b_dly) begin m_axil_bvalid = 1'b1; m_axil_bresp = cfg_resp; end
                else b_cnt++;
            end
            m_axil_rvalid = 1'b0;
            if (ar_got) begin
                if (r_cnt >= cfg_r_dly) begin
                    m_axil_rvalid = 1'b1;
                    m_axil_rresp  = cfg_resp;
                    m_axil_rdata  = cfg_rover ? cfg_rdata :
                                    (slave_mem.exists(rd_addr) ? slave_mem[rd_addr] : 32'h0);
                end else r_cnt++;
            end

            p_awv = m_axil_awvalid; p_awr = m_axil_awready; p_awaddr = m_axil_awaddr;
            p_wv = m_axil_wvalid; p_wr = m_axil_wready; p_wdata = m_axil_wdata; p_wstrb = m_axil_wstrb;
            p_bv = m_axil_bvalid; p_br = m_axil_bready;
            p_arv = m_axil_arvalid; p_arr = m_axil_arready; p_araddr = m_axil_araddr;
            p_rv = m_axil_rvalid; p_rr = m_axil_rready;
        end
    end

    task automatic set_cfg(input int awd, input int wd, input int bd, input int ard, input int rd,
                           input logic [1:0] rsp, input bit rover, input logic [31:0] rov);
        cfg_aw_dly = awd; cfg_w_dly = wd; cfg_b_dly = bd; cfg_ar_dly = ard; cfg_r_dly = rd;
        cfg_resp = rsp; cfg_rover = rover; cfg_rdata = rov;
    endtask

    // One complete command/response exchange; lat = cycle of first rsp_valid after acceptance
    task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [31:0] rdata,
                           output logic [1:0] resp, output logic rwr, output int lat);
        int guard, na, nw, nb, nar, nr, hold;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        guard = 0;
        while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
        check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        na = n_aw; nw = n_w; nb = n_b; nar = n_ar; nr = n_r;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        check("rsp_valid_timeout", 64'(rsp_valid), 64'(1));
        rdata = rsp_rdata; resp = rsp_resp; rwr = rsp_write;
        hold = $urandom_range(0, 2);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("rsp_stable", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}),
                  64'({1'b1, rwr, resp, rdata}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done_cmd_ready", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
        check("hs_counts", 64'({8'(n_aw - na), 8'(n_w - nw), 8'(n_b - nb), 8'(n_ar - nar), 8'(n_r - nr)}),
              wr ? 64'(40'h01_01_01_00_00) : 64'(40'h00_00_00_01_01));
        if (wr)
            model_mem[addr] = merge(model_mem.exists(addr) ? model_mem[addr] : 32'h0, data, strb);
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          awd, wd, bd, ard, rd;
        logic [1:0]  rsp_cfg;
        bit          rover;
        logic [31:0] rov;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] rd_v, exp_d, saved_d;
        logic [1:0]  rs_v, rsp_c, saved_r;
        logic        rw_v;
        int          lat, guard, awd, wd, bd, ard, rdl;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;

        // Zero-wait write/read, staggered AW/W, axil_ram-like delays, error responses, strobes
        vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 3};
        vecs[1] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 3, 0, 0, 0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 6};
        vecs[2] = '{1'b0, 16'h0010, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b00, 1'b0, 32'h0, 32'hDEADBEEF, 2'b00, 4};
        vecs[3] = '{1'b1, 16'h0020, 32'hCAFEF00D, 4'hF, 1, 1, 0, 0, 0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 4};
        vecs[4] = '{1'b0, 16'h0040, 32'h0, 4'h0, 0, 0, 0, 0, 5, 2'b10, 1'b1, 32'h12345678, 32'h12345678, 2'b10, 8};
        vecs[5] = '{1'b1, 16'h0010, 32'h0000ABCD, 4'h3, 2, 0, 2, 0, 0, 2'b10, 1'b0, 32'h0, 32'h0, 2'b10, 7};
        vecs[6] = '{1'b0, 16'h0010, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'b11, 1'b0, 32'h0, 32'hDEADABCD, 2'b11, 6};
        vecs[7] = '{1'b1, 16'h0024, 32'h11223344, 4'hC, 3, 1, 1, 0, 0, 2'b11, 1'b0, 32'h0, 32'h0, 2'b11, 7};
        vecs[8] = '{1'b0, 16'h0024, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 32'h11220000, 2'b00, 3};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({cmd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
              m_axil_arvalid, m_axil_rready, rsp_valid, rsp_write}), 64'(0));
        check("rst_rsp", 64'({rsp_resp, rsp_rdata}), 64'(0));
        check("rst_addr_data", 64'({m_axil_awaddr, m_axil_araddr, m_axil_wstrb}), 64'(0));
        check("rst_wdata", 64'(m_axil_wdata), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

        foreach (vecs[i]) begin
            set_cfg(vecs[i].awd, vecs[i].wd, vecs[i].bd, vecs[i].ard, vecs[i].rd,
                    vecs[i].rsp_cfg, vecs[i].rover, vecs[i].rov);
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, rd_v, rs_v, rw_v, lat);
            check($sformatf("vec%0d_write", i), 64'(rw_v), 64'(vecs[i].wr));
            check($sformatf("vec%0d_rdata", i), 64'(rd_v), 64'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_resp", i), 64'(rs_v), 64'(vecs[i].exp_resp));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
        end

        // Response back-pressure: response stable, new commands refused, no AXI activity
        set_cfg(0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0020;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'b1; cmd_addr = 16'h0030; cmd_wdata = 32'hA5A5F00F;
        cmd_wstrb = 4'hF;
        guard = 0;
        while (!rsp_valid && guard < 50) begin @(negedge clk); guard++; end
        check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
        check("bp_rdata", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'({1'b0, 2'b00, 32'hCAFEF00D}));
        saved_d = rsp_rdata; saved_r = rsp_resp;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = (i >= 3 && i < 6) || i >= 8;
            @(negedge clk);
            check("bp_rsp_stable", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}),
                  64'({1'b1, 1'b0, saved_r, saved_d}));
            check("bp_no_axi", 64'({cmd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}), 64'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_released", 64'({rsp_valid, cmd_ready, m_axil_awvalid}), 64'(3'b010));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_next_accepted", 64'({cmd_ready, m_axil_awvalid, m_axil_wvalid}), 64'(3'b011));
        guard = 0;
        while (!rsp_valid && guard < 50) begin @(negedge clk); guard++; end
        check("bp_next_rsp", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}), 64'({2'b11, 2'b00, 32'h0}));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        model_mem[16'h0030] = 32'hA5A5F00F;

        // Asynchronous reset while W is still waiting
        set_cfg(0, 10, 0, 0, 0, 2'b00, 1'b0, 32'h0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0050; cmd_wdata = 32'h55AA55AA;
        cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_mid_pre", 64'({m_axil_awvalid, m_axil_wvalid}), 64'(2'b11));
        @(negedge clk);
        check("rst_mid_w_held", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_wdata}),
              64'({2'b01, 32'h55AA55AA}));
        #2 rst = 1'b1;
        #1 check("rst_mid_valids", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                 m_axil_rready, rsp_valid, cmd_ready}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
        set_cfg(0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0);
        run_txn(1'b1, 16'h0050, 32'h0BADCAFE, 4'hF, rd_v, rs_v, rw_v, lat);
        check("post_rst_write", 64'({rw_v, rs_v, rd_v}), 64'({1'b1, 2'b00, 32'h0}));
        check("post_rst_latency", 64'(lat), 64'(3));
        run_txn(1'b0, 16'h0050, 32'h0, 4'h0, rd_v, rs_v, rw_v, lat);
        check("post_rst_read", 64'({rw_v, rs_v, rd_v}), 64'({1'b0, 2'b00, 32'h0BADCAFE}));

        // Randomized traffic against the scoreboard memory
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            addr = 16'($urandom_range(0, 7) * 4);
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            awd = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
            ard = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
            rsp_c = 2'($urandom_range(0, 3));
            exp_d = wr ? 32'h0 : (model_mem.exists(addr) ? model_mem[addr] : 32'h0);
            set_cfg(awd, wd, bd, ard, rdl, rsp_c, 1'b0, 32'h0);
            run_txn(wr, addr, data, strb, rd_v, rs_v, rw_v, lat);
            check($sformatf("rnd%0d_rsp", n), 64'({rw_v, rs_v, rd_v}), 64'({wr, rsp_c, exp_d}));
            check($sformatf("rnd%0d_latency", n), 64'(lat),
                  64'(wr ? 3 + ((awd > wd) ? awd : wd) + bd : 3 + ard + rdl));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
